// File: rtl/dft_scan_responder_pkg.sv
// Shared types and constants for the DFT scan-read responder.
// State encoding, packed word width and a word-count helper.
package dft_scan_responder_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACK    = 3'd1,
        S_SHIFT  = 3'd2,
        S_DRAIN  = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    // Number of packed words needed to carry a chain of the given length.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/simple_counter.sv
// Free-running up counter with synchronous clear and enable.
// Wraps to zero after reaching p_max.
module simple_counter #(
    parameter int                 p_width = 32,
    parameter logic [p_width-1:0] p_max   = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               cnten,
    output logic [p_width-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (cnten) begin
            count <= (count == p_max) ? '0 : count + p_width'(1);
        end
    end

endmodule

// File: rtl/dft_scan_responder.sv
// Responder side of the DFT scan-read handshake: circularly unloads one scan
// chain, packs the serial bits into words with a strobe, then commits.
module dft_scan_responder
    import dft_scan_responder_pkg::*;
#(
    parameter int p_chain_len  = 64,
    parameter int p_word_width = WORD_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dft_val_op,
    output logic                    dft_op_ack,
    output logic                    dft_op_commit,
    input  logic                    dft_commit_ack,
    output logic                    dft_output_strobe,
    output logic [p_word_width-1:0] dft_output_data,
    output logic                    scan_en,
    output logic                    scan_in,
    input  logic                    scan_out,
    output state_t                  dbg_state
);

    localparam int          IDX_W    = $clog2(p_word_width);
    localparam logic [31:0] LAST_BIT = 32'(p_chain_len - 1);

    state_t                  state;
    logic [31:0]             bit_cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [p_word_width-1:0] asm_q;
    logic [p_word_width-1:0] cap_word;
    logic                    last_bit;
    logic                    word_done;
    logic                    cnt_clr;
    logic                    cnt_en;

    assign cnt_clr = (state == S_IDLE);
    assign cnt_en  = (state == S_SHIFT);

    simple_counter #(
        .p_width (32),
        .p_max   (LAST_BIT)
    ) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .cnten (cnt_en),
        .count (bit_cnt)
    );

    assign bit_idx   = bit_cnt[IDX_W-1:0];
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign word_done = (&bit_idx) || last_bit;

    always_comb begin
        cap_word          = asm_q;
        cap_word[bit_idx] = scan_out;
    end

    // Loopback keeps the chain contents intact after a full rotation.
    assign scan_in   = scan_en & scan_out;
    assign dbg_state = state;

    // Handshake: the initiator raises dft_val_op; dft_op_ack answers one cycle
    // later and stays up while dft_val_op is held; the falling edge of
    // dft_val_op starts the unload. dft_op_commit then stays up until
    // dft_commit_ack, and a new request is only accepted once that ack drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            dft_op_ack        <= 1'b0;
            dft_op_commit     <= 1'b0;
            dft_output_strobe <= 1'b0;
            dft_output_data   <= '0;
            scan_en           <= 1'b0;
            asm_q             <= '0;
        end else begin
            dft_output_strobe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dft_val_op && !dft_commit_ack) begin
                        state      <= S_ACK;
                        dft_op_ack <= 1'b1;
                    end
                end
                S_ACK: begin
                    if (!dft_val_op) begin
                        state      <= S_SHIFT;
                        dft_op_ack <= 1'b0;
                        scan_en    <= 1'b1;
                        asm_q      <= '0;
                    end
                end
                S_SHIFT: begin
                    if (word_done) begin
                        dft_output_data   <= cap_word;
                        dft_output_strobe <= 1'b1;
                        asm_q             <= '0;
                    end else begin
                        asm_q <= cap_word;
                    end
                    if (last_bit) begin
                        state   <= S_DRAIN;
                        scan_en <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    state         <= S_COMMIT;
                    dft_op_commit <= 1'b1;
                end
                S_COMMIT: begin
                    if (dft_commit_ack) begin
                        state         <= S_IDLE;
                        dft_op_commit <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dft_scan_responder.sv
// Bench for dft_scan_responder: 40-bit and 32-bit chain instances with
// rotating chain models and expected-word queues.
module tb_dft_scan_responder;
    import dft_scan_responder_pkg::*;

    localparam int L40 = 40;
    localparam int L32 = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc++;

    logic        val40, ack40, commit40, cack40, stb40, se40, si40, so40;
    logic [31:0] data40;
    state_t      st40;
    logic        val32, ack32, commit32, cack32, stb32, se32, si32, so32;
    logic [31:0] data32;
    state_t      st32;

    logic [L40-1:0] ch40, pre40;
    logic [L32-1:0] ch32, pre32;
    logic           load40, load32;

    dft_scan_responder #(.p_chain_len(L40), .p_word_width(32)) u_dut40 (
        .clk(clk), .reset(reset), .dft_val_op(val40), .dft_op_ack(ack40),
        .dft_op_commit(commit40), .dft_commit_ack(cack40),
        .dft_output_strobe(stb40), .dft_output_data(data40),
        .scan_en(se40), .scan_in(si40), .scan_out(so40), .dbg_state(st40)
    );

    dft_scan_responder #(.p_chain_len(L32), .p_word_width(32)) u_dut32 (
        .clk(clk), .reset(reset), .dft_val_op(val32), .dft_op_ack(ack32),
        .dft_op_commit(commit32), .dft_commit_ack(cack32),
        .dft_output_strobe(stb32), .dft_output_data(data32),
        .scan_en(se32), .scan_in(si32), .scan_out(so32), .dbg_state(st32)
    );

    // Chain models: head at bit 0, tail (scan_out) at the top bit.
    assign so40 = ch40[L40-1];
    assign so32 = ch32[L32-1];

    always @(posedge clk) begin
        if (load40) ch40 <= pre40;
        else if (se40) ch40 <= {ch40[L40-2:0], si40};
        if (load32) ch32 <= pre32;
        else if (se32) ch32 <= {ch32[L32-2:0], si32};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Bit k of the shift order sits at chain position len-1-k, so the mapping
    // between shift-order bits and chain contents is its own inverse.
    function automatic logic [L40-1:0] rev40(input logic [L40-1:0] v);
        logic [L40-1:0] r;
        for (int k = 0; k < L40; k++) r[L40-1-k] = v[k];
        return r;
    endfunction

    function automatic logic [L32-1:0] rev32(input logic [L32-1:0] v);
        logic [L32-1:0] r;
        for (int k = 0; k < L32; k++) r[L32-1-k] = v[k];
        return r;
    endfunction

    // Scoreboard and monitor for the 40-bit instance
    logic [31:0] exp_q[$];
    int          stb_cyc[$];
    int          se_cnt, stb_cnt, commit_hi, commit_rise;
    logic        commit_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (se40) begin
                se_cnt++;
                checkb("loopback40", si40, so40);
            end
            checkb("scan_en_only_in_shift40", se40 && (st40 != S_SHIFT), 1'b0);
            checkb("strobe_commit_overlap40", stb40 && commit40, 1'b0);
            if (stb40) begin
                stb_cnt++;
                stb_cyc.push_back(cyc);
                checkb("strobe_expected40", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("word40", data40, exp_q.pop_front());
            end
            if (commit40) begin
                commit_hi++;
                if (!commit_prev) commit_rise = cyc;
            end
        end
        commit_prev = commit40;
    end

    // Scoreboard and monitor for the 32-bit instance
    logic [31:0] exp32_q[$];
    int          se32_cnt, stb32_cnt, stb32_cyc, commit32_rise;
    logic        commit32_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (se32) se32_cnt++;
            if (stb32) begin
                stb32_cnt++;
                stb32_cyc = cyc;
                checkb("strobe_expected32", exp32_q.size() != 0, 1'b1);
                if (exp32_q.size() != 0) check("word32", data32, exp32_q.pop_front());
            end
            if (commit32 && !commit32_prev) commit32_rise = cyc;
        end
        commit32_prev = commit32;
    end

    // One full unload on the 40-bit instance; called at a negedge in IDLE.
    task automatic run_unload(input int hold, input int ack_delay,
                              input logic [31:0] w0, input logic [31:0] w1);
        logic [L40-1:0] start;
        int             t;
        start = ch40;
        exp_q.push_back(w0);
        exp_q.push_back(w1);
        se_cnt = 0; stb_cnt = 0; commit_hi = 0; commit_rise = -1;
        stb_cyc.delete();
        checkb("ack_before_request", ack40, 1'b0);
        val40 = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkb("ack_held", ack40, 1'b1);
            checkb("no_scan_en_in_ack", se40, 1'b0);
        end
        val40 = 1'b0;
        @(negedge clk);
        checkb("ack_released", ack40, 1'b0);
        checkb("first_scan_en", se40, 1'b1);
        t = 0;
        while (!commit40 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checkb("commit_within_bound", commit40, 1'b1);
        for (int i = 1; i < ack_delay; i++) @(negedge clk);
        cack40 = 1'b1;
        @(negedge clk);
        checkb("commit_dropped", commit40, 1'b0);
        check("idle_after_commit", 32'(st40), 32'(S_IDLE));
        check("scan_en_cycles", se_cnt, L40);
        check("strobe_count", stb_cnt, ceil_div(L40, 32));
        if (stb_cyc.size() == 2) begin
            check("strobe_spacing", stb_cyc[1] - stb_cyc[0], L40 % 32);
            check("commit_after_last_strobe", commit_rise - stb_cyc[1], 1);
        end
        check("commit_high_cycles", commit_hi, ack_delay);
        check("scoreboard_empty", exp_q.size(), 0);
        checkb("chain_restored", ch40 == start, 1'b1);
    endtask

    logic [L40-1:0] bits;
    logic [31:0]    nw0, nw1;
    int             t32;

    initial begin
        reset = 1'b1;
        val40 = 1'b0; cack40 = 1'b0; load40 = 1'b0;
        val32 = 1'b0; cack32 = 1'b0; load32 = 1'b0;
        pre40 = rev40({8'h5A, 32'hDEADBEEF});
        pre32 = rev32(32'h12345678);
        se32_cnt = 0; stb32_cnt = 0; stb32_cyc = -1; commit32_rise = -1;
        repeat (3) @(negedge clk);

        checkb("reset_ack", ack40, 1'b0);
        checkb("reset_commit", commit40, 1'b0);
        checkb("reset_strobe", stb40, 1'b0);
        check("reset_data", data40, 32'h0);
        checkb("reset_scan_en", se40, 1'b0);
        check("reset_state", 32'(st40), 32'(S_IDLE));
        check("reset_state32", 32'(st32), 32'(S_IDLE));
        checkb("reset_strobe32", stb32, 1'b0);

        load40 = 1'b1; load32 = 1'b1;
        @(negedge clk);
        load40 = 1'b0; load32 = 1'b0;
        reset = 1'b0;

        // 5-cycle request, 10-cycle commit ack delay
        run_unload(5, 10, 32'hDEADBEEF, 32'h0000005A);

        // Request while the previous commit_ack is still high is ignored
        val40 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkb("stale_commit_ack_blocks_ack", ack40, 1'b0);
            check("stale_commit_ack_state", 32'(st40), 32'(S_IDLE));
        end
        val40 = 1'b0; cack40 = 1'b0;
        @(negedge clk);

        // Back-to-back unload yields the same words
        run_unload(1, 1, 32'hDEADBEEF, 32'h0000005A);
        cack40 = 1'b0;
        @(negedge clk);

        // Reset at SHIFT bit 17
        val40 = 1'b1;
        @(negedge clk);
        val40 = 1'b0;
        @(negedge clk);
        checkb("shift_started", se40, 1'b1);
        repeat (17) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkb("midreset_ack", ack40, 1'b0);
        checkb("midreset_commit", commit40, 1'b0);
        checkb("midreset_strobe", stb40, 1'b0);
        check("midreset_data", data40, 32'h0);
        checkb("midreset_scan_en", se40, 1'b0);
        checkb("midreset_scan_in", si40, 1'b0);
        check("midreset_state", 32'(st40), 32'(S_IDLE));
        reset = 1'b0;
        @(negedge clk);

        // Clean unload of the partially rotated chain
        bits = rev40(ch40);
        nw0  = bits[31:0];
        nw1  = {24'h0, bits[39:32]};
        run_unload(2, 3, nw0, nw1);
        cack40 = 1'b0;
        @(negedge clk);

        // 32-bit chain: single word, no padding word
        exp32_q.push_back(32'h12345678);
        val32 = 1'b1;
        @(negedge clk);
        val32 = 1'b0;
        t32 = 0;
        while (!commit32 && t32 < 200) begin
            @(negedge clk);
            t32++;
        end
        checkb("commit32_within_bound", commit32, 1'b1);
        cack32 = 1'b1;
        @(negedge clk);
        cack32 = 1'b0;
        @(negedge clk);
        check("strobe_count32", stb32_cnt, ceil_div(L32, 32));
        check("scan_en_cycles32", se32_cnt, L32);
        check("commit_after_strobe32", commit32_rise - stb32_cyc, 1);
        check("scoreboard32_empty", exp32_q.size(), 0);
        checkb("chain32_restored", ch32 == pre32, 1'b1);
        check("idle32", 32'(st32), 32'(S_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
